// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// program_counter : PC register; increments by PC_INCR or loads jump_addr.
// Optional macro PC_JUMP_ALIGN_EN forces jump targets to word alignment.
// Revision: 1.0
// ============================================================================
module program_counter #(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                  PC_INCR    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PC_WIDTH-1:0] jump_addr,
  output logic [PC_WIDTH-1:0] pc_addr
);

  localparam logic [PC_WIDTH-1:0] C_INCR = PC_WIDTH'(PC_INCR);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] w_jump_target;

`ifdef PC_JUMP_ALIGN_EN
  assign w_jump_target = {jump_addr[PC_WIDTH-1:2], 2'b00};
`else
  assign w_jump_target = jump_addr;
`endif

  // Increment wraps modulo 2^PC_WIDTH by truncation of the sum.
  always_comb begin
    pc_d = pc_q + C_INCR;
    if (enable) begin
      pc_d = w_jump_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_addr = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// Testbench for program_counter: directed scenarios plus randomized traffic
// checked against a behavioural PC model.
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] jump_addr;
  logic [31:0] pc_addr;

  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] exp_pc;

  program_counter #(
    .PC_WIDTH  (32),
    .RESET_ADDR(32'h0000_0000),
    .PC_INCR   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .jump_addr(jump_addr),
    .pc_addr  (pc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] jump_target(input logic [31:0] ja);
`ifdef PC_JUMP_ALIGN_EN
    return ja & ~32'h3;
`else
    return ja;
`endif
  endfunction

  // Advance one rising edge and update the reference with the sampled inputs.
  task automatic tick();
    @(posedge clk);
    if (rst)         exp_pc = 32'h0;
    else if (enable) exp_pc = jump_target(jump_addr);
    else             exp_pc = exp_pc + 32'd4;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; jump_addr = 32'h0; exp_pc = 32'h0;
    #1;
    vectors++;
    if (pc_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", pc_addr, 32'h0);
    end
    enable = 1'b1; jump_addr = 32'd100;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (pc_addr !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, pc_addr, 32'h0);
      end
    end
    enable = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      vectors++;
      if (pc_addr !== 32'(4 * i) || exp_pc !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL incr_seq[%0d]: got %h expected %h", i, pc_addr, 32'(4 * i));
      end
    end
  endtask

  task automatic test_jump();
    enable = 1'b1; jump_addr = 32'd32;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      vectors++;
      if (pc_addr !== 32'(32 + 4 * i)) begin
        miscompares++;
        $display("FAIL jump_seq[%0d]: got %h expected %h", i, pc_addr, 32'(32 + 4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    enable = 1'b1; jump_addr = 32'hFFFF_FFF8;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      vectors++;
      if (pc_addr !== want[i]) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, pc_addr, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; jump_addr = 32'd100;
    #2;
    rst = 1'b1; exp_pc = 32'h0;
    #1;
    vectors++;
    if (pc_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL async_rst_now: got %h expected %h", pc_addr, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc_addr !== 32'h0) begin
        miscompares++;
        $display("FAIL async_rst_hold[%0d]: got %h expected %h", i, pc_addr, 32'h0);
      end
    end
    rst = 1'b0; enable = 1'b0;
  endtask

  task automatic test_align();
    logic [31:0] want;
`ifdef PC_JUMP_ALIGN_EN
    want = 32'h20;
`else
    want = 32'h23;
`endif
    enable = 1'b1; jump_addr = 32'h23;
    tick();
    enable = 1'b0;
    vectors++;
    if (pc_addr !== want) begin
      miscompares++;
      $display("FAIL align_jump: got %h expected %h", pc_addr, want);
    end
    tick();
    vectors++;
    if (pc_addr !== want + 32'd4) begin
      miscompares++;
      $display("FAIL align_incr: got %h expected %h", pc_addr, want + 32'd4);
    end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1; jump_addr = 32'd64;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc_addr !== 32'd64) begin
        miscompares++;
        $display("FAIL hold_jump[%0d]: got %h expected %h", i, pc_addr, 32'd64);
      end
    end
    enable = 1'b0;
    tick();
    vectors++;
    if (pc_addr !== 32'd68) begin
      miscompares++;
      $display("FAIL hold_release: got %h expected %h", pc_addr, 32'd68);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom_range(0, 3) == 0);
      jump_addr = $urandom();
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1; exp_pc = 32'h0;
        #1;
        vectors++;
        if (pc_addr !== 32'h0) begin
          miscompares++;
          $display("FAIL rand_async_rst[%0d]: got %h expected %h", i, pc_addr, 32'h0);
        end
      end
      tick();
      vectors++;
      if (pc_addr !== exp_pc) begin
        miscompares++;
        $display("FAIL rand[%0d]: got %h expected %h", i, pc_addr, exp_pc);
      end
      if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
    end
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_sequence();
    test_jump();
    test_wrap();
    test_async_reset();
    test_align();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
